// File: rtl/instr_fetch_queue.sv
// Instruction prefetch buffer feeding IF/ID: sequential fetch over req/ack, small FIFO, branch redirect flush.
// Optional combinational ack-to-output bypass when the FIFO is empty: define FETCH_QUEUE_BYPASS_EN.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [63:0]             imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_data,
  input  logic                    redirect,
  input  logic [63:0]             redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_pc,
  output logic [31:0]             out_ins,
  output logic [$clog2(DEPTH):0]  out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic          req_q;
  logic [63:0]   fetch_pc;
  logic [63:0]   drop_addr;
  logic [63:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          ack_ok;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic          fifo_valid;
  logic          room_next;

  // An ack only delivers a word when it answers a live (non-stale) request and no redirect kills it.
  always_comb begin
    ack_ok      = (state == REQ) && imem_ack && !redirect;
    fifo_valid  = (count != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_take = ack_ok && !fifo_valid && out_ready;
`else
    bypass_take = 1'b0;
`endif
    push        = ack_ok && !bypass_take;
    pop         = fifo_valid && out_ready && !redirect;
    count_next  = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    if (redirect) begin
      count_next = '0;
    end
    room_next   = (count_next < FULL);
  end

  always_comb begin
    imem_req  = req_q;
    imem_addr = (state == DROP) ? drop_addr : fetch_pc;
    out_count = count;
    out_valid = fifo_valid;
    out_pc    = fifo_valid ? pc_mem[rd_ptr]  : 64'd0;
    out_ins   = fifo_valid ? ins_mem[rd_ptr] : 32'd0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (!fifo_valid && ack_ok) begin
      out_valid = 1'b1;
      out_pc    = imem_addr;
      out_ins   = imem_data;
    end
`endif
  end

  // A redirect while a request is outstanding must wait out that ack in DROP, holding the stale address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      req_q    <= 1'b1;
      case (state)
        REQ: begin
          if (imem_ack) begin
            state <= REQ;
          end else begin
            state     <= DROP;
            drop_addr <= fetch_pc;
          end
        end
        DROP:    state <= imem_ack ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (room_next) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc <= fetch_pc + 64'd4;
            if (!room_next) begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state <= REQ;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= imem_addr;
      ins_mem[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed scoreboard bench for instr_fetch_queue: expected (pc, ins, cycle) pushed by stimulus, popped by a monitor.
module tb_instr_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_ins;
  logic [2:0]  out_count;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   mem_lat  = 0;
  int   mem_wait = 0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(64'h100)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .out_count(out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle 0 is the cycle in which reset is first seen low; the DUT is still in its reset state then.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic applyStimulus(input logic ready, input logic redir, input logic [63:0] rpc);
    out_ready   = ready;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expectWord(input logic [63:0] pc, input int c);
    exp_t e;
    e.pc  = pc;
    e.ins = word_at(pc);
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req"},   {63'd0, imem_req},  64'd0);
    checkOutput({tag, "_addr"},  imem_addr,          64'h100);
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    checkOutput({tag, "_pc"},    out_pc,             64'd0);
    checkOutput({tag, "_ins"},   {32'd0, out_ins},   64'd0);
    checkOutput({tag, "_count"}, {61'd0, out_count}, 64'd0);
  endtask

  // Memory model: acks after mem_lat wait cycles of a continuous request; dropping req abandons it.
  initial begin
    imem_ack  = 1'b0;
    imem_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!imem_req) begin
        imem_ack = 1'b0;
        mem_wait = 0;
      end else if (mem_wait >= mem_lat) begin
        imem_ack  = 1'b1;
        imem_data = word_at(imem_addr);
        mem_wait  = 0;
      end else begin
        imem_ack = 1'b0;
        mem_wait++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && out_valid && out_ready && !redirect) begin
        if (sb.size() == 0) begin
          checkOutput("sb_has_entry", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("pop_pc",    out_pc,           e.pc);
          checkOutput("pop_ins",   {32'd0, out_ins}, {32'd0, e.ins});
          checkOutput("pop_cycle", 64'(cyc),         64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0);

    // Zero-wait memory streams one word per cycle.
    mem_lat = 0;
    applyStimulus(1'b1, 1'b0, 64'd0);
    doReset();
    for (int k = 0; k < 8; k++) expectWord(64'h100 + 64'(4 * k), k + 2 - BYP);
    #1 checkResetState("t1_reset");
    waitCycle(1);
    #1 checkOutput("t1_req_c1", {63'd0, imem_req}, 64'd1);
    checkOutput("t1_addr_c1", imem_addr, 64'h100);
    waitCycle(10 - BYP);
    applyStimulus(1'b0, 1'b0, 64'd0);
    #1 checkOutput("t1_drained", 64'(sb.size()), 64'd0);

    // Stalled consumer fills the FIFO, fetch stops, then resumes.
    applyStimulus(1'b0, 1'b0, 64'd0);
    doReset();
    waitCycle(4);
    #1 checkOutput("t2_req_c4", {63'd0, imem_req}, 64'd1);
    checkOutput("t2_count_c4", {61'd0, out_count}, 64'd3);
    waitCycle(5);
    #1 checkOutput("t2_req_c5", {63'd0, imem_req}, 64'd0);
    checkOutput("t2_count_c5", {61'd0, out_count}, 64'd4);
    checkOutput("t2_valid_c5", {63'd0, out_valid}, 64'd1);
    waitCycle(6);
    for (int k = 0; k < 6; k++) expectWord(64'h100 + 64'(4 * k), 6 + k);
    applyStimulus(1'b1, 1'b0, 64'd0);
    #1 checkOutput("t2_req_c6", {63'd0, imem_req}, 64'd0);
    waitCycle(7);
    #1 checkOutput("t2_req_c7", {63'd0, imem_req}, 64'd1);
    checkOutput("t2_addr_c7", imem_addr, 64'h110);
    waitCycle(12);
    applyStimulus(1'b0, 1'b0, 64'd0);
    #1 checkOutput("t2_drained", 64'(sb.size()), 64'd0);

    // Redirect during a slow fetch: stale ack dropped, target fetched next.
    mem_lat = 3;
    applyStimulus(1'b1, 1'b0, 64'd0);
    doReset();
    expectWord(64'h400, 9 - BYP);
    waitCycle(2);
    applyStimulus(1'b1, 1'b1, 64'h400);
    #1 checkOutput("t3_addr_c2", imem_addr, 64'h100);
    waitCycle(3);
    applyStimulus(1'b1, 1'b0, 64'd0);
    #1 checkOutput("t3_addr_c3", imem_addr, 64'h100);
    checkOutput("t3_req_c3", {63'd0, imem_req}, 64'd1);
    waitCycle(4);
    #1 checkOutput("t3_valid_c4", {63'd0, out_valid}, 64'd0);
    waitCycle(5);
    #1 checkOutput("t3_addr_c5", imem_addr, 64'h400);
    checkOutput("t3_count_c5", {61'd0, out_count}, 64'd0);
    waitCycle(11);
    #1 checkOutput("t3_drained", 64'(sb.size()), 64'd0);

    // Redirect against a full FIFO with the consumer ready: flush wins, no pop.
    mem_lat = 0;
    applyStimulus(1'b0, 1'b0, 64'd0);
    doReset();
    waitCycle(6);
    applyStimulus(1'b1, 1'b1, 64'h800);
    expectWord(64'h800, 8 - BYP);
    #1 checkOutput("t4_count_c6", {61'd0, out_count}, 64'd4);
    waitCycle(7);
    applyStimulus(1'b1, 1'b0, 64'd0);
    #1 checkOutput("t4_count_c7", {61'd0, out_count}, 64'd0);
    checkOutput("t4_valid_c7", {63'd0, out_valid}, 64'(BYP));
    checkOutput("t4_req_c7", {63'd0, imem_req}, 64'd1);
    checkOutput("t4_addr_c7", imem_addr, 64'h800);
    waitCycle(9 - BYP);
    applyStimulus(1'b0, 1'b0, 64'd0);
    #1 checkOutput("t4_drained", 64'(sb.size()), 64'd0);

    // Two redirects while one ack is pending: only the last target is fetched.
    mem_lat = 3;
    applyStimulus(1'b1, 1'b0, 64'd0);
    doReset();
    expectWord(64'h300, 9 - BYP);
    waitCycle(2);
    applyStimulus(1'b1, 1'b1, 64'h200);
    waitCycle(3);
    applyStimulus(1'b1, 1'b1, 64'h300);
    #1 checkOutput("t5_addr_c3", imem_addr, 64'h100);
    waitCycle(4);
    applyStimulus(1'b1, 1'b0, 64'd0);
    #1 checkOutput("t5_addr_c4", imem_addr, 64'h100);
    checkOutput("t5_count_c4", {61'd0, out_count}, 64'd0);
    waitCycle(5);
    #1 checkOutput("t5_addr_c5", imem_addr, 64'h300);
    waitCycle(11);
    #1 checkOutput("t5_drained", 64'(sb.size()), 64'd0);

    // Reset while a request is outstanding.
    applyStimulus(1'b1, 1'b0, 64'd0);
    doReset();
    waitCycle(2);
    reset = 1'b1;
    #1 checkOutput("t6_req_pre", {63'd0, imem_req}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    expectWord(64'h100, 5 - BYP);
    #1 checkResetState("t6_reset");
    waitCycle(1);
    #1 checkOutput("t6_req_c1", {63'd0, imem_req}, 64'd1);
    checkOutput("t6_addr_c1", imem_addr, 64'h100);
    waitCycle(7);
    #1 checkOutput("t6_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
